// File: rtl/gps_sample_packer_pkg.sv
`default_nettype none
// ====================================================================
// gps_sample_packer_pkg : nibble/byte layout and packer FSM encoding
// Rev 1.0
// ====================================================================
package gps_sample_packer_pkg;

  typedef enum logic [0:0] {
    ST_HI = 1'b0,
    ST_LO = 1'b1
  } pack_state_t;

  // Bit positions of the front-end outputs within a 4-bit sample
  localparam int c_nib_i1 = 3;
  localparam int c_nib_i0 = 2;
  localparam int c_nib_q1 = 1;
  localparam int c_nib_q0 = 0;

  // Older sample in the upper nibble, newer sample in the lower nibble
  localparam int c_byte_old_lsb = 4;
  localparam int c_byte_new_lsb = 0;

  function automatic logic [3:0] pack_nibble(input logic i1, input logic i0,
                                             input logic q1, input logic q0);
    logic [3:0] nib;
    nib           = '0;
    nib[c_nib_i1] = i1;
    nib[c_nib_i0] = i0;
    nib[c_nib_q1] = q1;
    nib[c_nib_q0] = q0;
    return nib;
  endfunction

  function automatic logic [7:0] pack_byte(input logic [3:0] older,
                                           input logic [3:0] newer);
    logic [7:0] b;
    b                         = '0;
    b[c_byte_old_lsb +: 4]    = older;
    b[c_byte_new_lsb +: 4]    = newer;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gps_sample_packer_sync_fifo.sv
`default_nettype none
// ====================================================================
// sync_fifo : circular FIFO with extra-MSB pointers, fill and flags
// Rev 1.0
// ====================================================================
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_fill    = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // A pop frees the head slot on the same edge, so a full FIFO can still take a write
  assign w_do_rd = i_rd_en && !o_empty;
  assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gps_sample_packer.sv
`default_nettype none
// ====================================================================
// gps_sample_packer : packs GPS I/Q sample pairs into buffered bytes
// Rev 1.0
// ====================================================================
module gps_sample_packer
  import gps_sample_packer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   GPS_CLK_16_368,
  input  logic                   GPS_RST_N,
  input  logic                   GPS_I0,
  input  logic                   GPS_I1,
  input  logic                   GPS_Q0,
  input  logic                   GPS_Q1,
  input  logic                   ENABLE,
  output logic [7:0]             OUT_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [$clog2(DEPTH):0] FILL,
  output logic                   OVERFLOW,
  input  logic                   CLR_OVF,
  output logic [CNT_W-1:0]       DROP_COUNT
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [3:0]       r_cap;
  logic [3:0]       r_hold;
  pack_state_t      r_state;
  pack_state_t      w_state_nxt;
  logic             w_wr;
  logic             w_hold_ld;
  logic [7:0]       w_byte;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_drop;
  logic             r_ovf;
  logic [CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge GPS_CLK_16_368) begin
    if (!GPS_RST_N) begin
      r_cap   <= '0;
      r_hold  <= '0;
      r_state <= ST_HI;
    end else begin
      r_cap   <= pack_nibble(GPS_I1, GPS_I0, GPS_Q1, GPS_Q0);
      r_state <= w_state_nxt;
      if (w_hold_ld) begin
        r_hold <= r_cap;
      end
    end
  end

  // ENABLE qualifies the nibble already sitting in the capture register
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_hold_ld   = 1'b0;
    if (!ENABLE) begin
      w_state_nxt = ST_HI;
    end else begin
      case (r_state)
        ST_HI: begin
          w_hold_ld   = 1'b1;
          w_state_nxt = ST_LO;
        end
        ST_LO: begin
          w_wr        = 1'b1;
          w_state_nxt = ST_HI;
        end
        default: w_state_nxt = ST_HI;
      endcase
    end
  end

  assign w_byte = pack_byte(r_hold, r_cap);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (GPS_CLK_16_368),
    .rst_n     (GPS_RST_N),
    .i_wr_en   (w_wr),
    .i_wr_data (w_byte),
    .i_rd_en   (OUT_READY),
    .o_rd_data (OUT_DATA),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_fill    (FILL)
  );

  assign OUT_VALID = !w_empty;
  assign w_pop     = OUT_VALID && OUT_READY;
  assign w_drop    = w_wr && w_full && !w_pop;

  // A drop coinciding with a clear is still recorded as the first drop
  always_ff @(posedge GPS_CLK_16_368) begin
    if (!GPS_RST_N) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (CLR_OVF) begin
      r_ovf      <= w_drop;
      r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != c_cnt_max) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign OVERFLOW   = r_ovf;
  assign DROP_COUNT = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gps_sample_packer.sv
`default_nettype none
// ====================================================================
// tb_gps_sample_packer : scoreboard bench for gps_sample_packer
// Rev 1.0
// ====================================================================
module tb_gps_sample_packer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic       clk = 1'b0;
  logic       GPS_RST_N = 1'b0;
  logic       GPS_I0 = 1'b0, GPS_I1 = 1'b0, GPS_Q0 = 1'b0, GPS_Q1 = 1'b0;
  logic       ENABLE = 1'b0;
  logic       OUT_READY = 1'b0;
  logic       CLR_OVF = 1'b0;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic [2:0] FILL;
  logic       OVERFLOW;
  logic [CNT_W-1:0] DROP_COUNT;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb [$];
  bit         pend_tag = 1'b0;
  logic       rst_n_drv = 1'b0;

  always #5 clk = ~clk;

  gps_sample_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .GPS_CLK_16_368 (clk),
    .GPS_RST_N      (GPS_RST_N),
    .GPS_I0         (GPS_I0),
    .GPS_I1         (GPS_I1),
    .GPS_Q0         (GPS_Q0),
    .GPS_Q1         (GPS_Q1),
    .ENABLE         (ENABLE),
    .OUT_DATA       (OUT_DATA),
    .OUT_VALID      (OUT_VALID),
    .OUT_READY      (OUT_READY),
    .FILL           (FILL),
    .OVERFLOW       (OVERFLOW),
    .CLR_OVF        (CLR_OVF),
    .DROP_COUNT     (DROP_COUNT)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ENABLE is driven one cycle after the nibble it tags, matching the capture stage
  task automatic cyc(input logic [3:0] nib, input bit tag, input bit rdy, input bit clr = 1'b0);
    @(negedge clk);
    #1;
    {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = nib;
    ENABLE    = pend_tag;
    pend_tag  = tag;
    OUT_READY = rdy;
    CLR_OVF   = clr;
    GPS_RST_N = rst_n_drv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, OUT_VALID, 0);
    check({tag, "_data"},  OUT_DATA, 0);
    check({tag, "_fill"},  FILL, 0);
    check({tag, "_ovf"},   OVERFLOW, 0);
    check({tag, "_drop"},  DROP_COUNT, 0);
  endtask

  // Monitor: every accepted byte must match the scoreboard head
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      #3;
      if (GPS_RST_N === 1'b1 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got %0h expected no byte", OUT_DATA);
        end else begin
          exp = sb.pop_front();
          check("pop_data", OUT_DATA, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] nib;

    // Reset
    rst_n_drv = 1'b0;
    cyc(4'h0, 1'b0, 1'b0);
    cyc(4'h0, 1'b0, 1'b0);
    check_reset_values("reset");
    rst_n_drv = 1'b1;

    // Packing order: {1,0,1,1} then {0,1,0,0} -> 0xB4
    sb.push_back(8'hB4);
    cyc(4'hB, 1'b1, 1'b1);
    cyc(4'h4, 1'b1, 1'b1);
    check("t1_valid_at_capture", OUT_VALID, 0);
    cyc(4'h0, 1'b0, 1'b1);
    check("t1_valid", OUT_VALID, 1);
    check("t1_data", OUT_DATA, 8'hB4);
    cyc(4'h0, 1'b0, 1'b1);
    check("t1_fill_after_pop", FILL, 0);

    // Back-pressure without loss
    sb.push_back(8'h12);
    sb.push_back(8'h34);
    sb.push_back(8'h56);
    sb.push_back(8'h78);
    for (int i = 0; i < 8; i++) begin
      nib = 4'(i + 1);
      cyc(nib, 1'b1, 1'b0);
      if (i >= 2) check("t2_data_stable", OUT_DATA, 8'h12);
    end
    cyc(4'h0, 1'b0, 1'b0);
    check("t2_fill", FILL, 4);
    check("t2_ovf", OVERFLOW, 0);
    check("t2_data_held", OUT_DATA, 8'h12);
    for (int j = 0; j < 4; j++) begin
      cyc(4'h0, 1'b0, 1'b1);
      check("t2_drain_fill", FILL, 32'(3 - j));
    end

    // Overflow: 10 bytes offered, 4 stored
    sb.push_back(8'h0F);
    sb.push_back(8'h1E);
    sb.push_back(8'h2D);
    sb.push_back(8'h3C);
    for (int i = 0; i < 20; i++) begin
      nib = (i % 2 == 0) ? 4'(i / 2) : 4'(15 - i / 2);
      cyc(nib, 1'b1, 1'b0);
    end
    cyc(4'h0, 1'b0, 1'b0);
    check("t3_fill", FILL, 4);
    check("t3_ovf", OVERFLOW, 1);
    check("t3_drop", DROP_COUNT, 6);
    cyc(4'h0, 1'b0, 1'b0, 1'b1);
    check("t3_clr_ovf", OVERFLOW, 0);
    check("t3_clr_drop", DROP_COUNT, 0);
    check("t3_clr_fill", FILL, 4);
    check("t3_clr_data", OUT_DATA, 8'h0F);

    // Full with a simultaneous pop
    sb.push_back(8'hE7);
    cyc(4'hE, 1'b1, 1'b0);
    cyc(4'h7, 1'b1, 1'b0);
    cyc(4'h0, 1'b0, 1'b1);
    check("t4_fill", FILL, 4);
    check("t4_drop", DROP_COUNT, 0);
    check("t4_ovf", OVERFLOW, 0);
    check("t4_head", OUT_DATA, 8'h1E);
    for (int j = 0; j < 4; j++) cyc(4'h0, 1'b0, 1'b1);
    check("t4_drained", FILL, 0);

    // ENABLE drop mid-pair: 9 is discarded, 6 untagged, byte is 0xC3
    sb.push_back(8'hC3);
    cyc(4'h9, 1'b1, 1'b1);
    cyc(4'h6, 1'b0, 1'b1);
    cyc(4'hC, 1'b1, 1'b1);
    check("t5_no_half_byte", OUT_VALID, 0);
    cyc(4'h3, 1'b1, 1'b1);
    check("t5_no_byte_yet", OUT_VALID, 0);
    cyc(4'h0, 1'b0, 1'b1);
    check("t5_valid", OUT_VALID, 1);
    check("t5_data", OUT_DATA, 8'hC3);
    cyc(4'h0, 1'b0, 1'b1);

    // Saturation, clear coinciding with a drop, then reset mid-stream
    sb.push_back(8'h05);
    sb.push_back(8'h15);
    sb.push_back(8'h25);
    sb.push_back(8'h35);
    for (int i = 0; i < 26; i++) begin
      nib = (i % 2 == 0) ? 4'(i / 2) : 4'h5;
      cyc(nib, 1'b1, 1'b0);
      if (i == 20) check("t6_drop_6", DROP_COUNT, 6);
      if (i == 24) check("t6_drop_sat", DROP_COUNT, 7);
    end
    cyc(4'h0, 1'b0, 1'b0, 1'b1);
    check("t6_clr_drop_same", DROP_COUNT, 1);
    check("t6_clr_ovf_same", OVERFLOW, 1);
    check("t6_fill_full", FILL, 4);
    cyc(4'h0, 1'b0, 1'b1);
    check("t6_fill_3", FILL, 3);
    sb.delete();
    rst_n_drv = 1'b0;
    cyc(4'h0, 1'b0, 1'b0);
    check_reset_values("midreset");
    rst_n_drv = 1'b1;
    sb.push_back(8'h5A);
    cyc(4'h5, 1'b1, 1'b1);
    cyc(4'hA, 1'b1, 1'b1);
    cyc(4'h0, 1'b0, 1'b1);
    check("t6_repack_data", OUT_DATA, 8'h5A);
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h0, 1'b0, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
